// File: rtl/fetch_pkg.sv
// Shared widths, reset PC and buffered-entry layout for the instruction fetch stage.
package fetch_pkg;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam logic [AW-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM port, redirect/halt from execute, and the decode handshake.
interface instr_fetch_if #(
  parameter int AW = fetch_pkg::AW,
  parameter int DW = fetch_pkg::DW
);
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic          br_valid;
  logic [AW-1:0] br_target;
  logic          halt;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;

  modport master (
    output rom_addr, instr_valid, instr, instr_pc,
    input  rom_q, br_valid, br_target, halt, instr_ready
  );

  modport slave (
    input  rom_addr, instr_valid, instr, instr_pc,
    output rom_q, br_valid, br_target, halt, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched (instr, pc) entries; flush empties it in one edge.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: head is only observed when count is non-zero.
  always_ff @(posedge CLK) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  a_no_overflow:  assert property (@(posedge CLK) disable iff (RST) !(push && full && !flush));
  a_no_underflow: assert property (@(posedge CLK) disable iff (RST) !(pop && empty && !flush));
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one ROM read per cycle when buffer room allows,
// captures the registered ROM word a cycle later and hands it to decode.
module instr_fetch #(
  parameter int            AW         = fetch_pkg::AW,
  parameter int            DW         = fetch_pkg::DW,
  parameter logic [AW-1:0] RESET_PC   = fetch_pkg::RESET_PC,
  parameter int            FIFO_DEPTH = 2
) (
  input  logic          CLK,
  input  logic          RST,
  instr_fetch_if.master bus
);
  import fetch_pkg::*;

  localparam int            CW      = $clog2(FIFO_DEPTH+1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [AW-1:0] pc, inflight_pc;
  logic          inflight;
  logic [DW-1:0] rom_word;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          empty, pop, issue;
  fetch_entry_t  head, push_data;

  assign rom_word  = bus.rom_q;
  assign push_data = '{instr: rom_word, pc: inflight_pc};

  // A redirect hides the head so decode can never take a wrong-path word.
  assign bus.instr_valid = !empty && !bus.br_valid;
  assign bus.instr       = empty ? '0 : head.instr;
  assign bus.instr_pc    = empty ? '0 : head.pc;
  assign bus.rom_addr    = pc;
  assign pop             = bus.instr_valid && bus.instr_ready;

  // Count the in-flight read as occupied so its capture always finds a slot.
  assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign issue = !bus.halt && !bus.br_valid && (occ < DEPTH_C);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.br_valid) begin
      pc       <= bus.br_target;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + 1'b1;
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .flush     (bus.br_valid),
    .push      (inflight),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty)
  );
endmodule
